// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    // Receiver frame states: wait for start edge, confirm start, shift data, check stop.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // 100 MHz system clock divided down to 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO with ready/valid on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends on ready, and enq_ready is also high when a full FIFO is being
// popped in the same cycle, so a simultaneous push/pop while full always succeeds.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             enq_fire;
    logic             deq_fire;

    // Extra MSB on each pointer separates "full" from "empty" when the indices match.
    assign empty     = (wptr == rptr);
    assign full      = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign deq_valid = !empty;
    assign deq_fire  = deq_valid & deq_ready;
    assign enq_ready = !full | deq_fire;
    assign enq_fire  = enq_valid & enq_ready;
    // Head is forced to zero while empty so the output reads 0 out of reset.
    assign deq_bits  = deq_valid ? mem[rptr[AW-1:0]] : '0;

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq_fire) wptr <= wptr + 1'b1;
            if (deq_fire) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are only visible through deq_bits when non-empty.
    always_ff @(posedge clock) begin
        if (enq_fire) mem[wptr[AW-1:0]] <= enq_bits;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, error pulses, receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rxd,
    output logic       io_deq_valid,
    input  logic       io_deq_ready,
    output logic [7:0] io_deq_bits,
    output logic       io_frame_err,
    output logic       io_overrun,
    output logic       io_busy
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    rx_state_t   state;
    logic        rxd_m;
    logic        rxd_s;
    logic        rxd_prev;
    logic [1:0]  sync_vld;
    logic        armed;
    logic        fall;
    logic [15:0] cnt;
    logic [2:0]  bitidx;
    logic [7:0]  shreg;
    logic        stop_sample;
    logic        enq_valid;
    logic        enq_ready;

    // Two-flop synchronizer plus edge history; sync_vld marks when rxd_s holds real line data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rxd_m    <= io_rxd;
            rxd_s    <= rxd_m;
            rxd_prev <= rxd_s;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rxd_s) armed <= 1'b1;
        end
    end

    // A line held low through reset release is ignored until it has been seen high.
    assign fall        = armed & rxd_prev & ~rxd_s;
    assign stop_sample = (state == RX_STOP) && (cnt == BIT_LAST);
    assign enq_valid   = stop_sample & rxd_s;

    // Frame FSM with counters and registered one-cycle error pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bitidx       <= '0;
            shreg        <= '0;
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;
        end else begin
            io_frame_err <= 1'b0;
            io_overrun   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= RX_IDLE;
                        end else begin
                            state  <= RX_DATA;
                            bitidx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        shreg[bitidx] <= rxd_s;
                        cnt           <= '0;
                        if (bitidx == 3'd7) state <= RX_STOP;
                        else bitidx <= bitidx + 3'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        state <= RX_IDLE;
                        cnt   <= '0;
                        if (!rxd_s) io_frame_err <= 1'b1;
                        else if (!enq_ready) io_overrun <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign io_busy = (state != RX_IDLE);

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (shreg),
        .deq_valid (io_deq_valid),
        .deq_ready (io_deq_ready),
        .deq_bits  (io_deq_bits)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_fifo;

    logic       clock;
    logic       reset;
    logic       io_rxd;
    logic       io_deq_valid;
    logic       io_deq_ready;
    logic [7:0] io_deq_bits;
    logic       io_frame_err;
    logic       io_overrun;
    logic       io_busy;

    uart_rx_fifo #(
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_rxd       (io_rxd),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_frame_err (io_frame_err),
        .io_overrun   (io_overrun),
        .io_busy      (io_busy)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int pops = 0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int first_valid_cyc = -1;
    int last_start_cyc = 0;
    logic prev_fe = 1'b0;
    logic prev_ov = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops expected bytes on every accepted dequeue, tracks error pulses
    always @(negedge clock) begin
        if (reset) begin
            if (io_deq_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (io_deq_valid && io_deq_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(io_deq_bits), -1);
                end else begin
                    check("deq_bits", 32'(io_deq_bits), 32'(exp_q.pop_front()));
                end
            end
            if (prev_fe) check("frame_err_width", 32'(io_frame_err), 0);
            if (prev_ov) check("overrun_width", 32'(io_overrun), 0);
            if (io_frame_err || io_overrun) check("err_exclusive", 32'(io_frame_err & io_overrun), 0);
            if (io_frame_err && !prev_fe) fe_cnt++;
            if (io_overrun && !prev_ov) ov_cnt++;
            prev_fe = io_frame_err;
            prev_ov = io_overrun;
        end else begin
            prev_fe = 1'b0;
            prev_ov = 1'b0;
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Send one 8N1 frame; optionally raise deq_ready only across the stop-sample edge.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit ready_pulse);
        logic [9:0] frame;
        int n;
        frame = {stop, b, 1'b0};
        n = 0;
        last_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            io_rxd = frame[i];
            repeat (16) begin
                @(posedge clock);
                #1;
                n++;
                if (ready_pulse && n == 154) io_deq_ready = 1'b1;
                if (ready_pulse && n == 155) io_deq_ready = 1'b0;
            end
        end
        io_rxd = 1'b1;
    endtask

    task automatic drain(input string name);
        io_deq_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check(name, exp_q.size(), 0);
    endtask

    int p0;
    int f0;
    int o0;

    initial begin
        reset = 1'b0;
        io_rxd = 1'b1;
        io_deq_ready = 1'b0;
        idle(5);
        check("rst_valid", 32'(io_deq_valid), 0);
        check("rst_bits", 32'(io_deq_bits), 0);
        check("rst_frame_err", 32'(io_frame_err), 0);
        check("rst_overrun", 32'(io_overrun), 0);
        check("rst_busy", 32'(io_busy), 0);
        reset = 1'b1;
        idle(10);

        // single byte with latency
        io_deq_ready = 1'b1;
        p0 = pops;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1, 1'b0);
        idle(10);
        check("single_latency", first_valid_cyc - last_start_cyc, 155);
        check("single_pops", pops - p0, 1);
        check("single_valid_cycles", valid_cycles, 1);
        check("single_frame_err", fe_cnt, 0);

        // back-to-back "Hi\n"
        p0 = pops;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h0A);
        send_byte(8'h48, 1'b1, 1'b0);
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'h0A, 1'b1, 1'b0);
        idle(10);
        check("b2b_pops", pops - p0, 3);
        check("b2b_queue", exp_q.size(), 0);
        check("b2b_errors", fe_cnt + ov_cnt, 0);

        // false start glitch
        p0 = pops;
        io_rxd = 1'b0;
        idle(5);
        io_rxd = 1'b1;
        idle(1);
        check("glitch_busy_high", 32'(io_busy), 1);
        idle(40);
        check("glitch_busy_low", 32'(io_busy), 0);
        check("glitch_pops", pops - p0, 0);
        check("glitch_valid", 32'(io_deq_valid), 0);
        check("glitch_errors", fe_cnt + ov_cnt, 0);

        // framing error then good byte
        p0 = pops;
        send_byte(8'hA3, 1'b0, 1'b0);
        idle(20);
        check("frame_err_count", fe_cnt, 1);
        check("frame_no_push", 32'(io_deq_valid), 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0);
        idle(10);
        check("frame_next_pops", pops - p0, 1);
        check("frame_err_stable", fe_cnt, 1);

        // overrun: fill and overflow
        io_deq_ready = 1'b0;
        o0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 1'b0);
        end
        idle(10);
        check("overrun_count", ov_cnt - o0, 1);
        check("overrun_full_valid", 32'(io_deq_valid), 1);
        drain("overrun_drain");

        // boundary: pop on the exact stop-sample edge while full
        io_deq_ready = 1'b0;
        idle(5);
        o0 = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 1'b0);
        end
        exp_q.push_back(8'h05);
        send_byte(8'h05, 1'b1, 1'b1);
        idle(10);
        check("boundary_no_overrun", ov_cnt - o0, 0);
        check("boundary_retained", exp_q.size(), 4);
        drain("boundary_drain");

        // reset mid-frame with a byte already buffered
        io_deq_ready = 1'b0;
        exp_q.push_back(8'h99);
        send_byte(8'h99, 1'b1, 1'b0);
        idle(5);
        check("pre_reset_valid", 32'(io_deq_valid), 1);
        io_rxd = 1'b0;
        idle(16);
        idle(16 * 3);
        idle(8);
        reset = 1'b0;
        idle(3);
        exp_q.delete();
        check("midrst_valid", 32'(io_deq_valid), 0);
        check("midrst_bits", 32'(io_deq_bits), 0);
        check("midrst_busy", 32'(io_busy), 0);
        check("midrst_errs", 32'(io_frame_err | io_overrun), 0);
        reset = 1'b1;
        idle(40);
        check("held_low_no_frame", 32'(io_busy), 0);
        io_rxd = 1'b1;
        idle(20);
        io_deq_ready = 1'b1;
        p0 = pops;
        f0 = fe_cnt;
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, 1'b0);
        idle(10);
        check("post_rst_pops", pops - p0, 1);
        check("post_rst_queue", exp_q.size(), 0);
        check("post_rst_no_err", fe_cnt - f0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
